// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared data-memory port: round-robin on ties,
// burst cap against starvation, registered read return per requester.
module dmem_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W:0] BURST_L = (CNT_W+1)'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN0,
    S_OWN1
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_gnt0;
  logic                w_gnt1;
  logic [CNT_W:0]      w_cnt_inc;
  logic                w_burst_end;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // Grant qualification and beat counting for the current owner.
  always_comb begin
    w_gnt0      = !i_reset && (r_state == S_OWN0) && i_req0;
    w_gnt1      = !i_reset && (r_state == S_OWN1) && i_req1;
    w_cnt_inc   = {1'b0, r_cnt} + (CNT_W+1)'(1);
    w_burst_end = (w_cnt_inc >= BURST_L);
    // Saturate so a long uncontended run cannot wrap and delay a later handover.
    w_cnt_nxt   = w_burst_end ? BURST_L[CNT_W-1:0] : w_cnt_inc[CNT_W-1:0];
  end

  // Memory port mux: driven by the owner, parked at zero when idle.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      S_OWN0: begin
        o_mem_addr  = i_addr0;
        o_mem_wdata = i_wdata0;
      end
      S_OWN1: begin
        o_mem_addr  = i_addr1;
        o_mem_wdata = i_wdata1;
      end
      default: begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
      end
    endcase
    o_mem_we = (w_gnt0 && i_we0) || (w_gnt1 && i_we1);
  end

  assign o_gnt0    = w_gnt0;
  assign o_gnt1    = w_gnt1;
  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  assign o_rdata0  = r_rdata0;
  assign o_rdata1  = r_rdata1;

  // Ownership state machine and registered read return.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 && !i_we0;
      r_rvalid1 <= w_gnt1 && !i_we1;
      if (w_gnt0 && !i_we0) r_rdata0 <= i_mem_rdata;
      if (w_gnt1 && !i_we1) r_rdata1 <= i_mem_rdata;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_req0 && i_req1) r_state <= r_last ? S_OWN0 : S_OWN1;
          else if (i_req0)      r_state <= S_OWN0;
          else if (i_req1)      r_state <= S_OWN1;
        end
        S_OWN0: begin
          if (w_gnt0) begin
            r_cnt  <= w_cnt_nxt;
            r_last <= 1'b0;
          end
          if (!i_req0) begin
            r_cnt   <= '0;
            r_state <= i_req1 ? S_OWN1 : S_IDLE;
          end else if (i_req1 && w_burst_end) begin
            r_cnt   <= '0;
            r_state <= S_OWN1;
          end
        end
        S_OWN1: begin
          if (w_gnt1) begin
            r_cnt  <= w_cnt_nxt;
            r_last <= 1'b1;
          end
          if (!i_req1) begin
            r_cnt   <= '0;
            r_state <= i_req0 ? S_OWN0 : S_IDLE;
          end else if (i_req0 && w_burst_end) begin
            r_cnt   <= '0;
            r_state <= S_OWN0;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus, behavioural ownership model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 64;
  localparam int MB = 4;

  logic          clk;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem  [64];
  logic [DW-1:0] mmem [64];

  int n_chk  = 0;
  int n_fail = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory environment: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: owner (-1 none), beats granted to owner, last winner.
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_last  = 1;
  int            mn;
  logic          m_rv [2] = '{1'b0, 1'b0};
  logic [DW-1:0] m_rd [2] = '{64'd0, 64'd0};
  logic          rq [2], wv [2], eg [2];
  logic [AW-1:0] av [2];
  logic [DW-1:0] dv [2];
  logic          ewe;
  logic [AW-1:0] ea;
  logic [DW-1:0] ewd;

  always @(negedge clk) begin
    rq[0] = req0;   rq[1] = req1;
    wv[0] = we0;    wv[1] = we1;
    av[0] = addr0;  av[1] = addr1;
    dv[0] = wdata0; dv[1] = wdata1;
    eg[0] = !reset && (m_owner == 0) && rq[0];
    eg[1] = !reset && (m_owner == 1) && rq[1];
    ewe   = (eg[0] && wv[0]) || (eg[1] && wv[1]);
    if (m_owner >= 0) begin
      ea  = av[m_owner];
      ewd = dv[m_owner];
    end else begin
      ea  = '0;
      ewd = '0;
    end
    chk("gnt0", gnt0, eg[0]);
    chk("gnt1", gnt1, eg[1]);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ewd);
    chk("rvalid0", rvalid0, m_rv[0]);
    chk("rvalid1", rvalid1, m_rv[1]);
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);

    if (reset) begin
      m_owner = -1; m_last = 1; m_beats = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      m_rd[0] = '0;   m_rd[1] = '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        m_rv[n] = eg[n] && !wv[n];
        if (m_rv[n]) m_rd[n] = mmem[av[n]];
      end
      if (ewe) mmem[ea] = ewd;
      if (m_owner < 0) begin
        if (rq[0] && rq[1]) m_owner = 1 - m_last;
        else if (rq[0])     m_owner = 0;
        else if (rq[1])     m_owner = 1;
        m_beats = 0;
      end else begin
        mn = m_owner;
        if (eg[mn]) begin
          m_beats++;
          m_last = mn;
        end
        if (!rq[mn]) begin
          m_owner = rq[1-mn] ? 1 - mn : -1;
          m_beats = 0;
        end else if (rq[1-mn] && m_beats >= MB) begin
          m_owner = 1 - mn;
          m_beats = 0;
        end
      end
    end
  end

  task automatic adv; @(posedge clk); #1; endtask
  task automatic obs; @(negedge clk); endtask

  int exp_pat [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int g;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]  <= 64'h1111_0000_0000_0000 + 64'(i);
      mmem[i]  = 64'h1111_0000_0000_0000 + 64'(i);
    end
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd3; wdata0 = 64'hA5A5_0000_0000_0033;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2; wdata1 = '0;

    // Reset held with both requesting and a write pending.
    repeat (3) begin
      obs;
      chk("rst_gnt0", gnt0, 1'b0);
      chk("rst_gnt1", gnt1, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
    end
    adv; reset = 1'b0;
    obs;
    chk("idle_gnt0", gnt0, 1'b0);
    chk("idle_gnt1", gnt1, 1'b0);

    // Continuous contention: burst cap alternates owners with no idle gap.
    for (int i = 0; i < 9; i++) begin
      obs;
      g = gnt0 ? 0 : (gnt1 ? 1 : 9);
      chk("burst_pat", 64'(g), 64'(exp_pat[i]));
    end
    adv; req0 = 1'b0; req1 = 1'b0;
    obs;
    adv; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    obs;
    chk("tie2_idle", gnt0 | gnt1, 1'b0);
    obs;
    chk("tie2_gnt1", gnt1, 1'b1);
    chk("tie2_gnt0", gnt0, 1'b0);
    adv; req0 = 1'b0; req1 = 1'b0;
    obs;

    // Requester 1: single write then read of address 5.
    adv; req1 = 1'b1; we1 = 1'b1; addr1 = 6'd5; wdata1 = 64'hDEAD_BEEF_0000_0001;
    obs; chk("wr_wait", gnt1, 1'b0);
    adv;
    obs; chk("wr_gnt1", gnt1, 1'b1); chk("wr_we", mem_we, 1'b1); chk("wr_addr", mem_addr, 6'd5);
    adv; we1 = 1'b0;
    obs; chk("rd_gnt1", gnt1, 1'b1); chk("rd_we", mem_we, 1'b0);
    adv; req1 = 1'b0;
    obs; chk("rd_rvalid1", rvalid1, 1'b1); chk("rd_rdata1", rdata1, 64'hDEAD_BEEF_0000_0001);
    adv;
    obs; chk("rd_rvalid1_off", rvalid1, 1'b0);

    // Core back-to-back reads of addresses 1, 2, 3.
    adv; req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
    obs; chk("b2b_wait", gnt0, 1'b0);
    adv;
    obs; chk("b2b_gnt0", gnt0, 1'b1);
    adv; addr0 = 6'd2;
    obs; chk("b2b_rv1", rvalid0, 1'b1); chk("b2b_rd1", rdata0, 64'h1111_0000_0000_0001);
    adv; addr0 = 6'd3;
    obs; chk("b2b_rv2", rvalid0, 1'b1); chk("b2b_rd2", rdata0, 64'h1111_0000_0000_0002);
    adv; req0 = 1'b0;
    obs; chk("b2b_rv3", rvalid0, 1'b1); chk("b2b_rd3", rdata0, 64'hA5A5_0000_0000_0033);
    adv;
    obs; chk("b2b_rv_off", rvalid0, 1'b0); chk("b2b_hold", rdata0, 64'hA5A5_0000_0000_0033);

    // Reset while requester 1 owns the port with a write pending.
    adv; req1 = 1'b1; we1 = 1'b0; addr1 = 6'd0;
    obs;
    adv; we1 = 1'b1; addr1 = 6'd7; wdata1 = 64'h0BAD_0BAD_0BAD_0BAD; reset = 1'b1;
    obs; chk("mid_rst_gnt1", gnt1, 1'b0); chk("mid_rst_we", mem_we, 1'b0);
    adv; reset = 1'b0;
    obs;
    chk("mid_rst_idle", gnt1, 1'b0);
    chk("mid_rst_rv0", rvalid0, 1'b0);
    chk("mid_rst_rv1", rvalid1, 1'b0);
    chk("mid_rst_mem7", mem[7], 64'h1111_0000_0000_0007);
    adv;
    obs; chk("post_rst_gnt1", gnt1, 1'b1); chk("post_rst_we", mem_we, 1'b1);
    adv; req1 = 1'b0;
    obs; chk("post_rst_mem7", mem[7], 64'h0BAD_0BAD_0BAD_0BAD);
    adv;
    obs;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
